// File: rtl/ycbcr2rgb_stream_if.sv
// ycbcr2rgb_stream_if: pixel-stream bundle for ycbcr2rgb_stream.
// The master drives the YCbCr beats and out_ready; the slave (the converter) drives the RGB side.
interface ycbcr2rgb_stream_if #(
  parameter int LANES = 8,
  parameter int BW = 3
);
  logic in_valid, in_ready, out_valid, out_ready, out_last;
  logic [8*LANES-1:0] in_y, in_cb, in_cr, out_r, out_g, out_b;
  logic [BW-1:0] out_beat;
  modport master(
    output in_valid, in_y, in_cb, in_cr, out_ready,
    input in_ready, out_valid, out_r, out_g, out_b, out_beat, out_last
  );
  modport slave(
    input in_valid, in_y, in_cb, in_cr, out_ready,
    output in_ready, out_valid, out_r, out_g, out_b, out_beat, out_last
  );
endinterface

// File: rtl/ycbcr2rgb_stream.sv
// ycbcr2rgb_stream: 2-stage pipelined JFIF YCbCr->RGB converter with beat framing and backpressure.
// Define YCBCR_SATCNT_EN to add the 16-bit saturating clamp counter port sat_count.
module ycbcr2rgb_stream #(
  parameter int BLK = 8,
  parameter int LANES = 8,
  parameter int FRAC = 8
) (
  input logic clk,
  input logic rst,
  ycbcr2rgb_stream_if.slave s
`ifdef YCBCR_SATCNT_EN
  ,
  output logic [15:0] sat_count
`endif
);
  localparam int BEATS = BLK * BLK / LANES;
  localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam int W = FRAC + 12;
  localparam logic signed [W-1:0] KRC = W'(((64'd1402000 << FRAC) + 64'd500000) / 64'd1000000);
  localparam logic signed [W-1:0] KGB = W'(((64'd344136 << FRAC) + 64'd500000) / 64'd1000000);
  localparam logic signed [W-1:0] KGC = W'(((64'd714136 << FRAC) + 64'd500000) / 64'd1000000);
  localparam logic signed [W-1:0] KBB = W'(((64'd1772000 << FRAC) + 64'd500000) / 64'd1000000);
  localparam logic signed [W-1:0] RND = W'(1) << (FRAC - 1);
  localparam logic signed [W-1:0] C128 = W'(128);
  localparam logic signed [W-1:0] MAX8 = W'(255);
  localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

  function automatic logic signed [W-1:0] ctr(input logic [7:0] c);
    return $signed(W'(c)) - C128;
  endfunction

  function automatic logic [7:0] clip(input logic signed [W-1:0] v);
    logic signed [W-1:0] t;
    t = v >>> FRAC;
    return t[W-1] ? 8'd0 : t > MAX8 ? 8'd255 : t[7:0];
  endfunction

  logic stall, acc;
  logic v1_q, v1_d, v2_q, v2_d;
  logic [BW-1:0] cnt_q, cnt_d, b1_q, b1_d, b2_q, b2_d;
  logic signed [W-1:0] yf_q [LANES], yf_d [LANES], pr_q [LANES], pr_d [LANES];
  logic signed [W-1:0] pgb_q [LANES], pgb_d [LANES], pgc_q [LANES], pgc_d [LANES];
  logic signed [W-1:0] pb_q [LANES], pb_d [LANES];
  logic signed [W-1:0] rs [LANES], gs [LANES], bs [LANES];
  logic [8*LANES-1:0] r_q, r_d, g_q, g_d, bb_q, bb_d;

  // in_ready depends only on the output register and out_ready, never on in_valid
  assign stall = v2_q & ~s.out_ready;
  assign acc = s.in_valid & ~stall;
  assign s.in_ready = ~stall;
  assign s.out_valid = v2_q;
  assign s.out_r = r_q;
  assign s.out_g = g_q;
  assign s.out_b = bb_q;
  assign s.out_beat = b2_q;
  assign s.out_last = v2_q & (b2_q == LAST);

  always_comb begin
    v1_d = acc;
    v2_d = v1_q;
    cnt_d = !acc ? cnt_q : cnt_q == LAST ? '0 : cnt_q + BW'(1);
    b1_d = cnt_q;
    b2_d = b1_q;
    for (int i = 0; i < LANES; i++) begin
      yf_d[i] = W'(s.in_y[8*i +: 8]) << FRAC;
      pr_d[i] = KRC * ctr(s.in_cr[8*i +: 8]);
      pgb_d[i] = KGB * ctr(s.in_cb[8*i +: 8]);
      pgc_d[i] = KGC * ctr(s.in_cr[8*i +: 8]);
      pb_d[i] = KBB * ctr(s.in_cb[8*i +: 8]);
      rs[i] = yf_q[i] + pr_q[i] + RND;
      gs[i] = yf_q[i] - pgb_q[i] - pgc_q[i] + RND;
      bs[i] = yf_q[i] + pb_q[i] + RND;
      r_d[8*i +: 8] = clip(rs[i]);
      g_d[8*i +: 8] = clip(gs[i]);
      bb_d[8*i +: 8] = clip(bs[i]);
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      cnt_q <= '0;
      b1_q <= '0;
      b2_q <= '0;
      yf_q <= '{default: '0};
      pr_q <= '{default: '0};
      pgb_q <= '{default: '0};
      pgc_q <= '{default: '0};
      pb_q <= '{default: '0};
      r_q <= '0;
      g_q <= '0;
      bb_q <= '0;
    end else if (!stall) begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      cnt_q <= cnt_d;
      b1_q <= b1_d;
      b2_q <= b2_d;
      yf_q <= yf_d;
      pr_q <= pr_d;
      pgb_q <= pgb_d;
      pgc_q <= pgc_d;
      pb_q <= pb_d;
      r_q <= r_d;
      g_q <= g_d;
      bb_q <= bb_d;
    end

`ifdef YCBCR_SATCNT_EN
  function automatic logic clipped(input logic signed [W-1:0] v);
    logic signed [W-1:0] t;
    t = v >>> FRAC;
    return t[W-1] | (t > MAX8);
  endfunction

  logic [3*LANES-1:0] sat_q, sat_d;
  logic [15:0] sc_q, sc_d;
  logic [16:0] sc_sum;

  // clamp flags ride in S2 next to the pixels they describe
  always_comb begin
    for (int i = 0; i < LANES; i++)
      sat_d[3*i +: 3] = {clipped(rs[i]), clipped(gs[i]), clipped(bs[i])};
    sc_sum = {1'b0, sc_q};
    for (int j = 0; j < 3*LANES; j++)
      sc_sum = sc_sum + 17'(sat_q[j]);
    sc_d = !(v2_q & s.out_ready) ? sc_q : sc_sum[16] ? 16'hFFFF : sc_sum[15:0];
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sat_q <= '0;
      sc_q <= '0;
    end else if (!stall) begin
      sat_q <= sat_d;
      sc_q <= sc_d;
    end

  assign sat_count = sc_q;
`endif
endmodule

// File: doc/ycbcr2rgb_stream.md
Name: ycbcr2rgb_stream

Overview:
Parametrised, pipelined JFIF YCbCr-to-RGB converter for the decoder back end, after IDCT/level-shift and before the pixel writer. It takes pixel blocks as a stream of LANES-pixel beats with valid/ready handshaking and backpressure. Each output beat carries its beat index within the block and an end-of-block marker. Conversion uses rounded fixed-point coefficients with clamping to 0..255.

Parameters:
BLK, 8, block edge in pixels; one block is BLK*BLK pixels.
LANES, 8, pixels per beat; must divide BLK*BLK. BEATS = BLK*BLK/LANES.
FRAC, 8, coefficient fraction bits, legal range 6..14.

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat this cycle
in_y  in  8*LANES  Y samples, unsigned; lane i occupies bits [8i+7:8i]
in_cb  in  8*LANES  Cb samples, unsigned, same lane layout
in_cr  in  8*LANES  Cr samples, unsigned, same lane layout
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts the beat
out_r  out  8*LANES  R, same lane layout
out_g  out  8*LANES  G, same lane layout
out_b  out  8*LANES  B, same lane layout
out_beat  out  max(1,$clog2(BEATS))  beat index within the block
out_last  out  1  high on beat BEATS-1 of each block

Behaviour:
- One clock (clk). Reset (rst) is asynchronous and active-high; all state clears immediately on assertion.
- Reset values: out_valid=0, out_r/out_g/out_b=0, out_beat=0, out_last=0, beat counter=0, all stage valids=0.
- Pipeline has 2 register stages; latency is exactly 2 cycles from input handshake to out_valid when there is no stall.
  - S1 registers: per-lane products and Y<<FRAC.
  - S2 registers: sums after rounding and clamping.
- Global stall: stall = out_valid & ~out_ready.
  - in_ready = ~stall. This path is combinational from out_ready; no dependency on in_valid.
  - While stalled, all stage registers and the beat counter hold.
  - A beat is accepted only when in_valid & in_ready.
  - Bubbles advance whenever not stalled.
- Coefficients are constants computed at elaboration: round(c*2^FRAC) for c = 1.402 (KRC), 0.344136 (KGB), 0.714136 (KGC), 1.772 (KBB).
  - For FRAC=8: KRC=359, KGB=88, KGC=183, KBB=454.
- Per lane, with signed dCb=Cb-128 and dCr=Cr-128:
  - R = (Y<<FRAC) + KRC*dCr + 2^(FRAC-1)
  - G = (Y<<FRAC) - KGB*dCb - KGC*dCr + 2^(FRAC-1)
  - B = (Y<<FRAC) + KBB*dCb + 2^(FRAC-1)
  - Intermediates are signed with width FRAC+12 minimum; there is no overflow anywhere in the legal range.
  - Result = arithmetic shift right by FRAC, then clamp: <0 gives 0, >255 gives 255.
- Beat counter: increments on each accepted input beat and wraps from BEATS-1 to 0.
  - The index travels with the data through the pipeline and appears on out_beat.
  - out_last = (out_beat == BEATS-1) & out_valid.
- Back-to-back blocks need no idle cycle; throughput is one beat per clock when out_ready is held at 1.
- out_* data may be any value when out_valid=0. While stalled, data is held stable, per AXI-style rules.
- Reset mid-block drops all in-flight beats; the next accepted beat after reset is beat 0.
- LANES=BLK*BLK (BEATS=1): out_beat is tied to 0 and out_last equals out_valid.

Optional Feature:
Macro YCBCR_SATCNT_EN.
- Defined: adds output port sat_count, 16 bits.
  - On each output handshake, sat_count increments by the number of lane components (R, G or B, up to 3*LANES) that were clamped at either bound.
  - It saturates at 0xFFFF and is cleared only by rst.
  - A per-component clamp flag is carried in S2 for this purpose.
- Undefined: the port and its logic are absent; conversion behaviour is identical.

Test Plan:
1. Neutral: all lanes Y=Cb=Cr=128, out_ready=1 -> R=G=B=128 in every lane, out_valid exactly 2 cycles after the handshake.
2. Clamp corners (FRAC=8): Y=255,Cb=128,Cr=255 -> R=255, G=164, B=255. Y=0,Cb=0,Cr=0 -> R=0, G=136, B=0. With SATCNT: 2 blocks of lane-0 stimulus add 2 per beat.
3. Block framing: 2 blocks, 16 consecutive beats -> out_beat runs 0..7,0..7; out_last high only on output beats 8 and 16; no gaps.
4. Backpressure: out_ready toggles randomly while in_valid is held at 1 -> no beat lost or duplicated, data stable while stalled, in_ready=0 exactly when out_valid&~out_ready.
5. Async reset: assert rst mid-block (beat 3) between clock edges -> out_valid=0 immediately; the next block starts at out_beat=0.
6. Random sweep vs reference model (rounded fixed-point, FRAC=8 and FRAC=12, LANES=4 and 8) -> bit-exact match on 10k beats.
